// File: rtl/nonconsec_rep_monitor_pkg.sv
// Shared types for the non-consecutive repetition monitor:
// FSM state encoding and the fail-cause code reported alongside fail.
package nonconsec_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    WAIT_TERM = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    EXTRA_EV = 2'd1,
    TIMEOUT  = 2'd2
  } fail_cause_e;

endpackage

// File: rtl/nonconsec_rep_monitor_sat_counter.sv
// Saturating up-counter used for the pass/fail tallies.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/nonconsec_rep_monitor.sv
// Hardware checker for trig |=> ev[=REP_COUNT] ##1 term, single-threaded,
// with registered pass/fail pulses, optional timeout and saturating tallies.
module nonconsec_rep_monitor
  import nonconsec_mon_pkg::*;
#(
  parameter int unsigned REP_COUNT = 3,
  parameter int unsigned MAX_WAIT  = 0,
  parameter int unsigned TALLY_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  input  logic               ev,
  input  logic               term,
  output logic               busy,
  output logic [7:0]         ev_cnt,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         fail_cause,
  output logic [TALLY_W-1:0] pass_tally,
  output logic [TALLY_W-1:0] fail_tally,
  output logic               ign_trig
);

  localparam int unsigned TIMER_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d, timer_inc;
  logic [7:0]          ev_cnt_d, ev_cnt_inc;
  logic                pass_d, fail_d, ign_d, resolve, timed_out;
  fail_cause_e         cause_d;

  always_comb begin
    state_d    = state_q;
    ev_cnt_d   = ev_cnt;
    timer_d    = timer_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    cause_d    = NONE;
    ign_d      = 1'b0;
    resolve    = 1'b0;
    ev_cnt_inc = ev_cnt + 8'd1;
    timer_inc  = (MAX_WAIT != 0) ? timer_q + TIMER_W'(1) : timer_q;
    timed_out  = (MAX_WAIT != 0) && (32'(timer_inc) == MAX_WAIT);

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = COUNT;
          ev_cnt_d = '0;
          timer_d  = '0;
        end
      end
      COUNT: begin
        timer_d = timer_inc;
        if (ev) begin
          ev_cnt_d = ev_cnt_inc;
          if (ev_cnt_inc == 8'(REP_COUNT)) state_d = WAIT_TERM;
        end
      end
      WAIT_TERM: begin
        timer_d = timer_inc;
        if (term) begin
          pass_d  = 1'b1;
          resolve = 1'b1;
        end else if (ev) begin
          fail_d  = 1'b1;
          cause_d = EXTRA_EV;
          resolve = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !resolve && timed_out) begin
      fail_d  = 1'b1;
      cause_d = TIMEOUT;
      resolve = 1'b1;
    end

    // A resolving edge may immediately re-arm; ev_cnt returns to 0 between attempts.
    if (resolve) begin
      state_d  = trig ? COUNT : IDLE;
      ev_cnt_d = '0;
      timer_d  = '0;
    end else if ((state_q != IDLE) && trig) begin
      ign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ev_cnt     <= '0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_cause <= '0;
      ign_trig   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ev_cnt     <= ev_cnt_d;
      busy       <= (state_d != IDLE);
      pass       <= pass_d;
      fail       <= fail_d;
      fail_cause <= cause_d;
      ign_trig   <= ign_d;
    end
  end

  sat_counter #(.WIDTH(TALLY_W)) u_pass_tally (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_d),
    .value (pass_tally)
  );

  sat_counter #(.WIDTH(TALLY_W)) u_fail_tally (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_d),
    .value (fail_tally)
  );

endmodule
